// File: rtl/sram_arb_pkg.sv
// Shared types and helpers for the SRAM port arbiter.
// Owns the FSM state encoding and round-robin index math.
package sram_arb_pkg;

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int rr_pos(
    input int base,
    input int k,
    input int n
  );
    return (base + k) % n;
  endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// Requester channels plus SRAM port of the arbiter.
// slave = arbiter side, master = requesters and SRAM.
interface sram_arbiter_if #(
  parameter int DEPTH   = 8,
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 2
);
  localparam int DEPTH_LOG = $clog2(DEPTH);

  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ-1:0]           req_we;
  logic [NUM_REQ-1:0]           req_lock;
  logic [NUM_REQ*DEPTH_LOG-1:0] req_addr;
  logic [NUM_REQ*WIDTH-1:0]     req_wdata;
  logic [NUM_REQ-1:0]           rsp_valid;
  logic [WIDTH-1:0]             rsp_data;
  logic                         sram_cs;
  logic                         sram_we;
  logic [DEPTH_LOG-1:0]         sram_ad;
  logic [WIDTH-1:0]             sram_din;
  logic [WIDTH-1:0]             sram_dout;

  modport slave (
    input  req_valid, req_we, req_lock,
    input  req_addr, req_wdata, sram_dout,
    output req_ready, rsp_valid, rsp_data,
    output sram_cs, sram_we, sram_ad, sram_din
  );

  modport master (
    output req_valid, req_we, req_lock,
    output req_addr, req_wdata, sram_dout,
    input  req_ready, rsp_valid, rsp_data,
    input  sram_cs, sram_we, sram_ad, sram_din
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick starting at i_ptr.
// Lowest offset from the pointer wins.
module rr_arbiter
  import sram_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  localparam int IW     = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IW-1:0]      i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IW-1:0]      o_idx
);

  // Scan far-to-near so the nearest request overwrites.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (i_req[rr_pos(int'(i_ptr), k, NUM_REQ)]) begin
        o_gnt = '0;
        o_gnt[rr_pos(int'(i_ptr), k, NUM_REQ)] = 1'b1;
        o_idx = IW'(rr_pos(int'(i_ptr), k, NUM_REQ));
      end
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin arbiter with burst lock in front of a
// single-port SRAM; one access per clock.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int WIDTH    = 32,
  parameter int NUM_REQ  = 2,
  localparam int DEPTH_LOG = $clog2(DEPTH),
  localparam int IW        = idx_w(NUM_REQ)
) (
  input  logic           clk,
  input  logic           rst_n,
  sram_arbiter_if.slave  bus
);

  state_t               r_state;
  state_t               w_state_n;
  logic [IW-1:0]        r_ptr;
  logic [IW-1:0]        w_ptr_n;
  logic [IW-1:0]        r_owner;
  logic [IW-1:0]        w_owner_n;

  logic [NUM_REQ-1:0]   w_arb_gnt;
  logic [IW-1:0]        w_arb_idx;
  logic [NUM_REQ-1:0]   w_own_oh;
  logic [NUM_REQ-1:0]   w_gnt;
  logic [IW-1:0]        w_idx;
  logic                 w_acc;

  logic                 r_cs;
  logic                 r_we;
  logic [DEPTH_LOG-1:0] r_ad;
  logic [WIDTH-1:0]     r_din;

  logic                 r_v1;
  logic                 r_v2;
  logic [IW-1:0]        r_i1;
  logic [IW-1:0]        r_i2;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .i_req (bus.req_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_arb_gnt),
    .o_idx (w_arb_idx)
  );

  assign w_own_oh = NUM_REQ'(1) << r_owner;

  always_comb begin
    w_gnt = '0;
    w_idx = '0;
    unique case (r_state)
      IDLE: begin
        w_gnt = w_arb_gnt;
        w_idx = w_arb_idx;
      end
      LOCKED: begin
        w_gnt = bus.req_valid & w_own_oh;
        w_idx = r_owner;
      end
    endcase
  end

  assign w_acc = |w_gnt;

  always_comb begin
    w_state_n = r_state;
    w_ptr_n   = r_ptr;
    w_owner_n = r_owner;
    if (w_acc) begin
      if (bus.req_lock[w_idx]) begin
        w_state_n = LOCKED;
        w_owner_n = w_idx;
      end else begin
        w_state_n = IDLE;
        w_ptr_n   = (w_idx == IW'(NUM_REQ - 1))
                  ? '0 : w_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
    end else begin
      r_state <= w_state_n;
      r_ptr   <= w_ptr_n;
      r_owner <= w_owner_n;
    end
  end

  // Address/data hold their last value when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cs  <= 1'b0;
      r_we  <= 1'b0;
      r_ad  <= '0;
      r_din <= '0;
    end else if (w_acc) begin
      r_cs  <= 1'b1;
      r_we  <= bus.req_we[w_idx];
      r_ad  <= bus.req_addr[w_idx*DEPTH_LOG +: DEPTH_LOG];
      r_din <= bus.req_wdata[w_idx*WIDTH +: WIDTH];
    end else begin
      r_cs  <= 1'b0;
      r_we  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_i1 <= '0;
      r_i2 <= '0;
    end else begin
      r_v1 <= w_acc & ~bus.req_we[w_idx];
      r_i1 <= w_idx;
      r_v2 <= r_v1;
      r_i2 <= r_i1;
    end
  end

  assign bus.req_ready = w_gnt;
  assign bus.rsp_valid = r_v2 ? (NUM_REQ'(1) << r_i2) : '0;
  assign bus.rsp_data  = bus.sram_dout;
  assign bus.sram_cs   = r_cs;
  assign bus.sram_we   = r_we;
  assign bus.sram_ad   = r_ad;
  assign bus.sram_din  = r_din;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural SRAM.
// Drives at posedge+1, samples at negedge.
module tb_sram_arbiter;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  logic [31:0] mem [8];

  sram_arbiter_if #(
    .DEPTH   (8),
    .WIDTH   (32),
    .NUM_REQ (2)
  ) bus ();

  sram_arbiter #(
    .DEPTH   (8),
    .WIDTH   (32),
    .NUM_REQ (2)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.sram_cs) begin
      if (bus.sram_we) mem[bus.sram_ad] <= bus.sram_din;
      else bus.sram_dout <= mem[bus.sram_ad];
    end
  end

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_lock  = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
  endtask

  task automatic drv(
    input int i,
    input bit we,
    input bit lk,
    input int a,
    input int d
  );
    bus.req_valid[i]          = 1'b1;
    bus.req_we[i]             = we;
    bus.req_lock[i]           = lk;
    bus.req_addr[i*3 +: 3]    = 3'(a);
    bus.req_wdata[i*32 +: 32] = 32'(d);
  endtask

  task automatic do_rst();
    tick();
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  logic [1:0] e_rdy;
  logic [1:0] e_rsp;
  logic [1:0] t4_rsp [7];

  initial begin
    n_chk  = 0;
    n_fail = 0;
    bus.sram_dout = '0;
    for (int i = 0; i < 8; i++) mem[i] = '0;
    idle();
    rst_n = 1'b0;

    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("rst_ready", 32'(bus.req_ready), 0);
      check("rst_rsp", 32'(bus.rsp_valid), 0);
      check("rst_cs", 32'(bus.sram_cs), 0);
      check("rst_we", 32'(bus.sram_we), 0);
      check("rst_ad", 32'(bus.sram_ad), 0);
      check("rst_din", bus.sram_din, 0);
    end
    tick();
    rst_n = 1'b1;
    @(negedge clk);

    // Burst: write 0..7 then read 0..7 from req0.
    for (int k = 0; k < 20; k++) begin
      tick();
      idle();
      if (k < 8) drv(0, 1, 0, k, 'h10 + k);
      else if (k < 16) drv(0, 0, 0, k - 8, 0);
      @(negedge clk);
      check("t2_ready", 32'(bus.req_ready),
            (k < 16) ? 1 : 0);
      check("t2_cs", 32'(bus.sram_cs),
            (k >= 1 && k <= 16) ? 1 : 0);
      check("t2_we", 32'(bus.sram_we),
            (k >= 1 && k <= 8) ? 1 : 0);
      check("t2_rsp", 32'(bus.rsp_valid),
            (k >= 10 && k <= 17) ? 1 : 0);
      if (k >= 10 && k <= 17)
        check("t2_data", bus.rsp_data, 'h10 + k - 10);
    end

    // Both requesters, no lock: grants alternate.
    do_rst();
    for (int k = 0; k < 6; k++) begin
      tick();
      idle();
      if (k < 4) begin
        drv(0, 0, 0, 3, 0);
        drv(1, 0, 0, 5, 0);
      end
      @(negedge clk);
      e_rdy = (k < 4) ? ((k % 2) ? 2'b10 : 2'b01) : 2'b00;
      e_rsp = (k >= 2) ? ((k % 2) ? 2'b10 : 2'b01) : 2'b00;
      check("t3_ready", 32'(bus.req_ready), 32'(e_rdy));
      check("t3_rsp", 32'(bus.rsp_valid), 32'(e_rsp));
      if (k >= 2)
        check("t3_data", bus.rsp_data,
              (k % 2) ? 'h15 : 'h13);
    end

    // Move pointer to 1, then req1 locks for 4 reads.
    do_rst();
    tick();
    idle();
    drv(0, 0, 0, 0, 0);
    @(negedge clk);
    check("t4_pre", 32'(bus.req_ready), 1);
    t4_rsp = '{2'b00, 2'b01, 2'b10, 2'b10,
               2'b10, 2'b10, 2'b01};
    for (int k = 0; k < 7; k++) begin
      tick();
      idle();
      if (k < 4) drv(1, 0, k < 3, 5, 0);
      if (k <= 4) drv(0, 0, 0, 3, 0);
      @(negedge clk);
      e_rdy = (k < 4) ? 2'b10 : ((k == 4) ? 2'b01 : 2'b00);
      check("t4_ready", 32'(bus.req_ready), 32'(e_rdy));
      check("t4_rsp", 32'(bus.rsp_valid), 32'(t4_rsp[k]));
      if (k == 1) check("t4_d0", bus.rsp_data, 'h10);
      if (k >= 2 && k <= 5)
        check("t4_d1", bus.rsp_data, 'h15);
      if (k == 6) check("t4_d2", bus.rsp_data, 'h13);
    end

    // Read-after-write across requesters.
    for (int k = 0; k < 4; k++) begin
      tick();
      idle();
      if (k == 0) drv(0, 1, 0, 2, 'hDEAD);
      if (k == 1) drv(1, 0, 0, 2, 0);
      @(negedge clk);
      e_rdy = (k == 0) ? 2'b01 : ((k == 1) ? 2'b10 : 2'b00);
      check("t5_ready", 32'(bus.req_ready), 32'(e_rdy));
      check("t5_rsp", 32'(bus.rsp_valid),
            (k == 3) ? 2 : 0);
      if (k == 3) check("t5_data", bus.rsp_data, 'hDEAD);
    end

    // Reset one cycle after a read accept.
    tick();
    idle();
    drv(0, 0, 0, 3, 0);
    @(negedge clk);
    check("t6_acc", 32'(bus.req_ready), 1);
    tick();
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    check("t6_rst_cs", 32'(bus.sram_cs), 0);
    check("t6_rst_rsp", 32'(bus.rsp_valid), 0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t6_norsp", 32'(bus.rsp_valid), 0);
      tick();
    end
    drv(0, 0, 0, 1, 0);
    drv(1, 0, 0, 1, 0);
    @(negedge clk);
    check("t6_ptr0", 32'(bus.req_ready), 1);
    tick();
    idle();
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d",
             n_chk, n_fail);
    $finish;
  end

endmodule
